adc_lane_bitslip_align: RTL and testbench



---
 rtl/adc_lane_bitslip_align.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_lane_bitslip_align.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_lane_bitslip_align.sv
// ---------------------------------------------------------------------------
// adc_lane_bitslip_align
//
// Per-lane word-alignment trainer for the ADC receive path. It sits after the
// per-lane deserializers and the bit-order remap. Each lane's 8-bit word is
// compared against a training pattern that has no rotational symmetry. While a
// lane is misaligned, the block sends one-cycle bitslip pulses back to that
// lane's deserializer. It stops when the lane shows LOCK_CNT consecutive
// matching words (LOCKED), or when MAX_SLIP slips have been spent and the lane
// still mismatches (FAIL).
//
// Every lane runs its own FSM. All lanes are (re)started together by a
// single-cycle train_start.
//
// Ports
//   clk          deserializer parallel-word clock
//   rst_n        asynchronous active-low reset
//   train_start  single-cycle request to (re)start training on all lanes
//   lane_data    deserialized words, lane n = remap lane n
//   bitslip      one-cycle bitslip request per lane
//   lane_locked  lane reached LOCKED
//   lane_fail    lane reached FAIL
//   slip_count   bitslips issued on the lane since the last train_start
//   align_busy   some lane is settling / checking / slipping (one cycle lag)
//   align_done   every lane is LOCKED or FAIL (one cycle lag)
//   align_ok     every lane is LOCKED (one cycle lag)
//
// Handshake: there is no valid/ready. lane_data is treated as valid on every
// clock. bitslip is a fire-and-forget pulse that the deserializer must honour
// within SETTLE_CYC cycles.
// ---------------------------------------------------------------------------
module adc_lane_bitslip_align #(
    parameter int                NUM_LANES     = 8,
    parameter int                SER_W         = 8,
    parameter logic [SER_W-1:0]  TRAIN_PATTERN = 8'h2D,
    parameter int                SETTLE_CYC    = 4,
    parameter int                LOCK_CNT      = 16,
    parameter int                MAX_SLIP      = SER_W,
    parameter int                SLIP_W        = $clog2(MAX_SLIP + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              train_start,
    input  logic [NUM_LANES-1:0][SER_W-1:0]   lane_data,
    output logic [NUM_LANES-1:0]              bitslip,
    output logic [NUM_LANES-1:0]              lane_locked,
    output logic [NUM_LANES-1:0]              lane_fail,
    output logic [NUM_LANES-1:0][SLIP_W-1:0]  slip_count,
    output logic                              align_busy,
    output logic                              align_done,
    output logic                              align_ok
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int MATCH_W  = $clog2(LOCK_CNT + 1);

    // Terminal counter values, pre-sized so the compares are width-exact.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_CNT - 1);
    localparam logic [SLIP_W-1:0]   SLIP_LIMIT  = SLIP_W'(MAX_SLIP);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } lane_state_e;

    // Current state of every lane. This array feeds the global reductions and
    // also gives an observation point for the lane FSMs.
    lane_state_e lane_state [NUM_LANES];

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lane_state_e               state_q, state_d;
        logic [SETTLE_W-1:0]       settle_cnt_q, settle_cnt_d;
        logic [MATCH_W-1:0]        match_cnt_q, match_cnt_d;
        logic [SLIP_W-1:0]         slip_cnt_q, slip_cnt_d;
        logic                      bitslip_q, locked_q, fail_q;

        always_comb begin
            state_d      = state_q;
            settle_cnt_d = settle_cnt_q;
            match_cnt_d  = match_cnt_q;
            slip_cnt_d   = slip_cnt_q;

            // A restart beats every other transition, including an in-flight
            // SLIP. That cycle's pulse has already been driven from the flop.
            if (train_start) begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
                match_cnt_d  = '0;
                slip_cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_SETTLE: begin
                        // lane_data is ignored here: the deserializer may
                        // still be applying the previous slip.
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_d = ST_CHECK;
                        end else begin
                            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (lane_data[n] == TRAIN_PATTERN) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                state_d = ST_LOCKED;
                            end else begin
                                match_cnt_d = match_cnt_q + MATCH_W'(1);
                            end
                        end else if (slip_cnt_q == SLIP_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            // A partial run earns no credit toward lock.
                            match_cnt_d = '0;
                            state_d     = ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        slip_cnt_d   = slip_cnt_q + SLIP_W'(1);
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                    ST_LOCKED: begin
                        state_d = ST_LOCKED;
                    end
                    ST_FAIL: begin
                        state_d = ST_FAIL;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // The output flops decode the next state. As a result the pulse and
        // status bits line up exactly with the cycle the lane sits in that
        // state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= ST_IDLE;
                settle_cnt_q <= '0;
                match_cnt_q  <= '0;
                slip_cnt_q   <= '0;
                bitslip_q    <= 1'b0;
                locked_q     <= 1'b0;
                fail_q       <= 1'b0;
            end else begin
                state_q      <= state_d;
                settle_cnt_q <= settle_cnt_d;
                match_cnt_q  <= match_cnt_d;
                slip_cnt_q   <= slip_cnt_d;
                bitslip_q    <= (state_d == ST_SLIP);
                locked_q     <= (state_d == ST_LOCKED);
                fail_q       <= (state_d == ST_FAIL);
            end
        end

        assign lane_state[n]  = state_q;
        assign bitslip[n]     = bitslip_q;
        assign lane_locked[n] = locked_q;
        assign lane_fail[n]   = fail_q;
        assign slip_count[n]  = slip_cnt_q;
    end

    // Global status: registered reductions over the current lane states.
    logic any_idle, any_active, all_final, all_locked;
    logic align_busy_d, align_done_d, align_ok_d;
    logic align_busy_q, align_done_q, align_ok_q;

    always_comb begin
        any_idle   = 1'b0;
        any_active = 1'b0;
        all_final  = 1'b1;
        all_locked = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_state[i] == ST_IDLE) begin
                any_idle = 1'b1;
            end
            if ((lane_state[i] == ST_SETTLE) || (lane_state[i] == ST_CHECK) ||
                (lane_state[i] == ST_SLIP)) begin
                any_active = 1'b1;
            end
            if ((lane_state[i] != ST_LOCKED) && (lane_state[i] != ST_FAIL)) begin
                all_final = 1'b0;
            end
            if (lane_state[i] != ST_LOCKED) begin
                all_locked = 1'b0;
            end
        end
        // Any idle lane forces all three low. all_final and all_locked are
        // already low in that case, so only busy needs the explicit mask.
        align_busy_d = any_active & ~any_idle;
        align_done_d = all_final;
        align_ok_d   = all_locked;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_busy_q <= 1'b0;
            align_done_q <= 1'b0;
            align_ok_q   <= 1'b0;
        end else begin
            align_busy_q <= align_busy_d;
            align_done_q <= align_done_d;
            align_ok_q   <= align_ok_d;
        end
    end

    assign align_busy = align_busy_q;
    assign align_done = align_done_q;
    assign align_ok   = align_ok_q;

endmodule

// File: tb/tb_adc_lane_bitslip_align.sv
// ---------------------------------------------------------------------------
// Bench for adc_lane_bitslip_align.
//
// A deserializer model feeds every lane. Each lane presents the training word
// rotated left by an offset, and every bitslip pulse reduces that offset by
// one, modulo 8.
//
// The reference model is event based. For each lane it records:
//   - the mode: idle / training / locked / fail
//   - the cycle from which words count
//   - the cycle of a scheduled slip pulse
//   - the running match count and the slip total
// From these it derives the expected outputs for every cycle.
// ---------------------------------------------------------------------------
module tb_adc_lane_bitslip_align;
    localparam int NL     = 8;
    localparam int W      = 8;
    localparam int SETTLE = 4;
    localparam int LOCK   = 16;
    localparam int MAXS   = 8;
    localparam int SW     = 4;
    localparam logic [7:0] PAT = 8'h2D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic train_start = 1'b0;
    logic [NL-1:0][W-1:0]  lane_data;
    logic [NL-1:0]         bitslip, lane_locked, lane_fail;
    logic [NL-1:0][SW-1:0] slip_count;
    logic align_busy, align_done, align_ok;

    always #5 clk = ~clk;

    adc_lane_bitslip_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .train_start (train_start),
        .lane_data   (lane_data),
        .bitslip     (bitslip),
        .lane_locked (lane_locked),
        .lane_fail   (lane_fail),
        .slip_count  (slip_count),
        .align_busy  (align_busy),
        .align_done  (align_done),
        .align_ok    (align_ok)
    );

    int cyc = 0;     // index of the current cycle (advances at posedge)
    int t0  = 0;     // cycle in which the latest train_start was driven
    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s rel_cyc=%0d actual=%0h expected=%0h", name, cyc - t0, act, exp);
    endtask

    // ---------------- deserializer model ----------------
    int offs [NL];
    bit dead [NL];
    int glitch_rel [NL];

    function automatic logic [7:0] rotl(input logic [7:0] p, input int k);
        logic [15:0] t;
        t = {p, p} << k;
        return t[15:8];
    endfunction

    task automatic drive_data();
        for (int n = 0; n < NL; n++) begin
            if (dead[n] || (cyc - t0 == glitch_rel[n])) lane_data[n] = 8'h00;
            else lane_data[n] = rotl(PAT, offs[n]);
        end
    endtask

    always @(posedge clk) begin : deser
        logic [NL-1:0] s;
        s = bitslip;
        #1;
        for (int n = 0; n < NL; n++) if (s[n]) offs[n] = (offs[n] + W - 1) % W;
        drive_data();
    end

    // ---------------- reference model ----------------
    int m_mode [NL];      // 0 idle, 1 training, 2 locked, 3 fail
    int m_check_at [NL];
    int m_run [NL];
    int m_slips [NL];
    int m_slip_at [NL];
    bit e_busy = 1'b0, e_done = 1'b0, e_ok = 1'b0;

    initial begin
        for (int n = 0; n < NL; n++) begin
            m_mode[n] = 0; m_check_at[n] = 0; m_run[n] = 0; m_slips[n] = 0; m_slip_at[n] = -1;
            offs[n] = 0; dead[n] = 1'b0; glitch_rel[n] = -100;
        end
        drive_data();
    end

    always @(posedge clk or negedge rst_n) begin : model
        int c;
        bit any_idle, any_tr, all_fin, all_lk;
        if (!rst_n) begin
            for (int n = 0; n < NL; n++) begin
                m_mode[n] = 0; m_run[n] = 0; m_slips[n] = 0; m_slip_at[n] = -1;
            end
            e_busy = 1'b0; e_done = 1'b0; e_ok = 1'b0;
        end else begin
            c = cyc;
            any_idle = 1'b0; any_tr = 1'b0; all_fin = 1'b1; all_lk = 1'b1;
            for (int n = 0; n < NL; n++) begin
                if (m_mode[n] == 0) any_idle = 1'b1;
                if (m_mode[n] == 1) any_tr = 1'b1;
                if (m_mode[n] < 2) all_fin = 1'b0;
                if (m_mode[n] != 2) all_lk = 1'b0;
            end
            e_busy = any_tr && !any_idle;
            e_done = all_fin;
            e_ok   = all_lk;
            for (int n = 0; n < NL; n++) begin
                if (train_start) begin
                    m_mode[n] = 1; m_check_at[n] = c + 1 + SETTLE;
                    m_run[n] = 0; m_slips[n] = 0; m_slip_at[n] = -1;
                end else if (m_mode[n] == 1) begin
                    if (m_slip_at[n] == c) begin
                        m_slips[n]++;
                    end else if (c >= m_check_at[n]) begin
                        if (lane_data[n] == PAT) begin
                            m_run[n]++;
                            if (m_run[n] == LOCK) m_mode[n] = 2;
                        end else if (m_slips[n] == MAXS) begin
                            m_mode[n] = 3;
                        end else begin
                            m_run[n] = 0;
                            m_slip_at[n] = c + 1;
                            m_check_at[n] = c + 2 + SETTLE;
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [NL-1:0] e_bs, e_lk, e_fl;
        logic [NL-1:0][SW-1:0] e_sc;
        if (chk_en) begin
            for (int n = 0; n < NL; n++) begin
                e_bs[n] = (m_slip_at[n] == cyc);
                e_lk[n] = (m_mode[n] == 2);
                e_fl[n] = (m_mode[n] == 3);
                e_sc[n] = SW'(m_slips[n]);
            end
            check("bitslip", 32'(bitslip), 32'(e_bs));
            check("lane_locked", 32'(lane_locked), 32'(e_lk));
            check("lane_fail", 32'(lane_fail), 32'(e_fl));
            check("slip_count", 32'(slip_count), 32'(e_sc));
            check("align_flags", {29'd0, align_busy, align_done, align_ok}, {29'd0, e_busy, e_done, e_ok});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup(input int off3, input bit dead5, input int glitch0);
        for (int n = 0; n < NL; n++) begin
            offs[n] = 0; dead[n] = 1'b0; glitch_rel[n] = -100;
        end
        offs[3] = off3;
        dead[5] = dead5;
        glitch_rel[0] = glitch0;
        drive_data();
    endtask

    task automatic start_train();
        @(posedge clk); #1;
        train_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        train_start = 1'b0;
    endtask

    task automatic goto(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog rel_cyc=%0d actual=timeout expected=finish", cyc - t0);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NL-1:0] seen;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_status", {lane_locked, lane_fail, bitslip}, 24'd0);
        check("reset_slip_count", 32'(slip_count), 32'd0);
        check("reset_align", {29'd0, align_busy, align_done, align_ok}, 32'd0);

        // Aligned lanes
        setup(0, 1'b0, -100);
        start_train();
        goto(20); check("t1_locked_c20", 32'(lane_locked), 32'h00);
        goto(21); check("t1_locked_c21", 32'(lane_locked), 32'hFF);
        check("t1_ok_c21", 32'(align_ok), 32'd0);
        goto(22); check("t1_done_ok_c22", {30'd0, align_done, align_ok}, 32'd3);
        check("t1_slip_count", 32'(slip_count), 32'd0);
        goto(30);

        // Lane 3 rotated by 3
        setup(3, 1'b0, -100);
        start_train();
        goto(6);  check("t2_bitslip_c6", 32'(bitslip), 32'h08);
        goto(12); check("t2_bitslip_c12", 32'(bitslip), 32'h08);
        goto(18); check("t2_bitslip_c18", 32'(bitslip), 32'h08);
        goto(21); check("t2_locked_c21", 32'(lane_locked), 32'hF7);
        goto(38); check("t2_locked_c38", 32'(lane_locked), 32'hF7);
        goto(39); check("t2_locked_c39", 32'(lane_locked), 32'hFF);
        check("t2_slip_count3", 32'(slip_count[3]), 32'd3);
        check("t2_ok_c39", 32'(align_ok), 32'd0);
        goto(40); check("t2_ok_c40", 32'(align_ok), 32'd1);
        goto(50);

        // Lane 5 dead
        setup(0, 1'b1, -100);
        start_train();
        goto(48); check("t3_bitslip_c48", 32'(bitslip), 32'h20);
        goto(53); check("t3_fail_c53", 32'(lane_fail), 32'h00);
        goto(54); check("t3_fail_c54", 32'(lane_fail), 32'h20);
        check("t3_slip_count5", 32'(slip_count[5]), 32'd8);
        goto(55); check("t3_done_ok_c55", {30'd0, align_done, align_ok}, 32'd2);
        goto(60);

        // Glitch on lane 0 at cycle 15
        setup(0, 1'b0, 15);
        start_train();
        goto(16); check("t4_bitslip_c16", 32'(bitslip), 32'h01);
        goto(21); check("t4_locked_c21", 32'(lane_locked), 32'hFE);
        goto(79); check("t4_locked_c79", 32'(lane_locked), 32'hFF);
        check("t4_slip_count0", 32'(slip_count[0]), 32'd8);
        goto(85);

        // Restart during lane 3 slipping
        setup(3, 1'b0, -100);
        start_train();
        goto(11);
        @(posedge clk); #1;
        check("t5_bitslip_c12", 32'(bitslip), 32'h08);
        train_start = 1'b1;
        @(posedge clk); #1;
        train_start = 1'b0;
        goto(13); check("t5_slip_count3_c13", 32'(slip_count[3]), 32'd0);
        goto(33); check("t5_locked_c33", 32'(lane_locked), 32'hF7);
        goto(39); check("t5_locked_c39", 32'(lane_locked), 32'hFF);
        goto(40); check("t5_ok_c40", 32'(align_ok), 32'd1);
        goto(50);

        // Reset mid-training
        setup(3, 1'b0, -100);
        start_train();
        goto(6); check("t6_bitslip_c6", 32'(bitslip), 32'h08);
        goto(7); check("t6_busy_c7", 32'(align_busy), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_status", {lane_locked, lane_fail, bitslip}, 24'd0);
        check("t6_rst_slip_count", 32'(slip_count), 32'd0);
        check("t6_rst_align", {29'd0, align_busy, align_done, align_ok}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= bitslip;
        end
        check("t6_no_bitslip_after_reset", 32'(seen), 32'd0);

        // Fresh training after reset
        setup(0, 1'b0, -100);
        start_train();
        goto(21); check("t7_locked_c21", 32'(lane_locked), 32'hFF);
        goto(22); check("t7_ok_c22", 32'(align_ok), 32'd1);
        goto(25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
